draw_cmd_encoder: RTL

Producer side of the 32-bit draw-command FIFO. Accepts one draw request per valid/ready handshake, range-checks it, and packs it into one or two FIFO words in the format the draw dispatcher decodes: opcode in bits [31:28], payload below. It sits between game or UI logic (e.g. snake_core) and the command FIFO, and replaces ad-hoc command packing in callers.

---
 rtl/draw_cmd_pkg.sv | 48 ++++
 rtl/draw_cmd_check.sv | 42 ++++
 rtl/draw_cmd_encoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/draw_cmd_pkg.sv
// Shared definitions for the draw-command encoder: FIFO opcodes, request
// type enum, field widths and the latched request payload.
package draw_cmd_pkg;

  localparam int unsigned FF_DATA_WIDTH = 32;
  localparam int unsigned OPC_WIDTH     = 4;
  localparam int unsigned REQ_OP_WIDTH  = 2;
  localparam int unsigned X_WIDTH       = 10;
  localparam int unsigned Y_WIDTH       = 9;
  localparam int unsigned SX_WIDTH      = 5;
  localparam int unsigned SY_WIDTH      = 5;
  localparam int unsigned COLOR_WIDTH   = 8;
  localparam int unsigned CODE_WIDTH    = 8;
  localparam int unsigned SIZE_WIDTH    = 4;
  localparam int unsigned CNT_WIDTH     = 16;

  // Opcodes as decoded by the draw dispatcher (word bits [31:28])
  localparam logic [OPC_WIDTH-1:0] OP_SPIXEL = 4'h0;
  localparam logic [OPC_WIDTH-1:0] OP_SRECT  = 4'h1;
  localparam logic [OPC_WIDTH-1:0] OP_PRECT  = 4'h9;
  localparam logic [OPC_WIDTH-1:0] OP_CHAR   = 4'hA;

  typedef enum logic [REQ_OP_WIDTH-1:0] {
    REQ_SPIXEL = 2'd0,
    REQ_SRECT  = 2'd1,
    REQ_PRECT  = 2'd2,
    REQ_CHAR   = 2'd3
  } req_op_e;

  // Request fields held while the command is written out
  typedef struct packed {
    req_op_e                op;
    logic [X_WIDTH-1:0]     x0;
    logic [Y_WIDTH-1:0]     y0;
    logic [X_WIDTH-1:0]     x1;
    logic [Y_WIDTH-1:0]     y1;
    logic [COLOR_WIDTH-1:0] color;
    logic [COLOR_WIDTH-1:0] bg;
    logic [CODE_WIDTH-1:0]  code;
    logic [SIZE_WIDTH-1:0]  size;
  } draw_req_t;

  // PRECT and CHAR occupy two FIFO words
  function automatic logic is_two_beat(req_op_e op);
    return (op == REQ_PRECT) || (op == REQ_CHAR);
  endfunction

endpackage

// File: rtl/draw_cmd_check.sv
// Combinational range validator for one draw request.
// Ports: op (request type), x0/y0/x1/y1 (full-width coordinates),
//        ok_c (1 = request is within range and correctly ordered).
module draw_cmd_check
  import draw_cmd_pkg::*;
#(
  parameter int unsigned H_LOGIC_MAX = 31,
  parameter int unsigned V_LOGIC_MAX = 23,
  parameter int unsigned H_PHY_MAX   = 639,
  parameter int unsigned V_PHY_MAX   = 479
) (
  input  req_op_e            op,
  input  logic [X_WIDTH-1:0] x0,
  input  logic [Y_WIDTH-1:0] y0,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  output logic               ok_c
);

  localparam logic [X_WIDTH-1:0] XL_MAX = X_WIDTH'(H_LOGIC_MAX);
  localparam logic [Y_WIDTH-1:0] YL_MAX = Y_WIDTH'(V_LOGIC_MAX);
  localparam logic [X_WIDTH-1:0] XP_MAX = X_WIDTH'(H_PHY_MAX);
  localparam logic [Y_WIDTH-1:0] YP_MAX = Y_WIDTH'(V_PHY_MAX);

  logic ordered;

  // Full-width compares: nonzero upper bits on superpixel ops fail too
  always_comb begin
    ok_c    = 1'b0;
    ordered = (x0 <= x1) && (y0 <= y1);
    case (op)
      REQ_SPIXEL: ok_c = (x0 <= XL_MAX) && (y0 <= YL_MAX);
      REQ_SRECT:  ok_c = (x0 <= XL_MAX) && (y0 <= YL_MAX) &&
                         (x1 <= XL_MAX) && (y1 <= YL_MAX) && ordered;
      REQ_PRECT:  ok_c = (x0 <= XP_MAX) && (y0 <= YP_MAX) &&
                         (x1 <= XP_MAX) && (y1 <= YP_MAX) && ordered;
      REQ_CHAR:   ok_c = (x0 <= XP_MAX) && (y0 <= YP_MAX);
      default:    ok_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/draw_cmd_encoder.sv
// Producer side of the 32-bit draw-command FIFO: accepts one request per
// valid/ready handshake, range-checks it and writes one or two FIFO words.
// Ports: clk, rst_n (async active-low); req_* request handshake and fields;
//        ff_full/ff_wren/ff_wdat FIFO write side; busy (not idle),
//        err (one-cycle reject pulse), cmd_cnt (accepted command count).
// ff_wren and req_rdy are decoded from the state register and ff_full so
// a full FIFO is honoured in the same cycle.
module draw_cmd_encoder
  import draw_cmd_pkg::*;
#(
  parameter int unsigned H_LOGIC_MAX = 31,
  parameter int unsigned V_LOGIC_MAX = 23,
  parameter int unsigned H_PHY_MAX   = 639,
  parameter int unsigned V_PHY_MAX   = 479
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [REQ_OP_WIDTH-1:0]  req_op,
  input  logic [X_WIDTH-1:0]       req_x0,
  input  logic [Y_WIDTH-1:0]       req_y0,
  input  logic [X_WIDTH-1:0]       req_x1,
  input  logic [Y_WIDTH-1:0]       req_y1,
  input  logic [COLOR_WIDTH-1:0]   req_color,
  input  logic [COLOR_WIDTH-1:0]   req_bg,
  input  logic [CODE_WIDTH-1:0]    req_code,
  input  logic [SIZE_WIDTH-1:0]    req_size,
  input  logic                     ff_full,
  output logic                     ff_wren,
  output logic [FF_DATA_WIDTH-1:0] ff_wdat,
  output logic                     busy,
  output logic                     err,
  output logic [CNT_WIDTH-1:0]     cmd_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_e;

  state_e    state;
  state_e    state_nxt;
  draw_req_t hold;
  req_op_e   op_in;
  logic      ok_c;
  logic      last_beat;
  logic      req_acc;
  logic      load;

  assign op_in = req_op_e'(req_op);

  draw_cmd_check #(
    .H_LOGIC_MAX (H_LOGIC_MAX),
    .V_LOGIC_MAX (V_LOGIC_MAX),
    .H_PHY_MAX   (H_PHY_MAX),
    .V_PHY_MAX   (V_PHY_MAX)
  ) u_check (
    .op   (op_in),
    .x0   (req_x0),
    .y0   (req_y0),
    .x1   (req_x1),
    .y1   (req_y1),
    .ok_c (ok_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake and write strobe
  always_comb begin
    state_nxt = state;
    req_rdy   = 1'b0;
    ff_wren   = 1'b0;
    last_beat = 1'b0;
    req_acc   = 1'b0;
    load      = 1'b0;

    case (state)
      ST_IDLE: begin
        req_rdy = 1'b1;
      end
      ST_BEAT0: begin
        ff_wren   = ~ff_full;
        last_beat = ~is_two_beat(hold.op);
        req_rdy   = last_beat & ~ff_full;
      end
      ST_BEAT1: begin
        ff_wren   = ~ff_full;
        last_beat = 1'b1;
        req_rdy   = ~ff_full;
      end
      default: ;
    endcase

    req_acc = req_vld & req_rdy;
    load    = req_acc & ok_c;

    case (state)
      ST_IDLE: begin
        if (load) state_nxt = ST_BEAT0;
      end
      ST_BEAT0: begin
        if (ff_wren) begin
          if (!last_beat) state_nxt = ST_BEAT1;
          else if (load)  state_nxt = ST_BEAT0;
          else            state_nxt = ST_IDLE;
        end
      end
      ST_BEAT1: begin
        if (ff_wren) state_nxt = load ? ST_BEAT0 : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Hold register, status flags and accepted-command counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      cmd_cnt <= '0;
    end else begin
      err  <= req_acc & ~ok_c;
      busy <= (state_nxt != ST_IDLE);
      if (load) begin
        hold.op    <= op_in;
        hold.x0    <= req_x0;
        hold.y0    <= req_y0;
        hold.x1    <= req_x1;
        hold.y1    <= req_y1;
        hold.color <= req_color;
        hold.bg    <= req_bg;
        hold.code  <= req_code;
        hold.size  <= req_size;
        cmd_cnt    <= cmd_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // FIFO word formatting from the held request
  always_comb begin
    ff_wdat = '0;
    case (state)
      ST_BEAT0: begin
        case (hold.op)
          REQ_SPIXEL: ff_wdat = {OP_SPIXEL, hold.x0[SX_WIDTH-1:0],
                                 hold.y0[SY_WIDTH-1:0], hold.color, 10'b0};
          REQ_SRECT:  ff_wdat = {OP_SRECT, hold.x0[SX_WIDTH-1:0],
                                 hold.y0[SY_WIDTH-1:0], hold.x1[SX_WIDTH-1:0],
                                 hold.y1[SY_WIDTH-1:0], hold.color};
          REQ_PRECT:  ff_wdat = {OP_PRECT, hold.x0, hold.y0, hold.color, 1'b0};
          REQ_CHAR:   ff_wdat = {OP_CHAR, hold.x0, hold.y0, hold.code, 1'b0};
          default:    ff_wdat = '0;
        endcase
      end
      ST_BEAT1: begin
        case (hold.op)
          REQ_PRECT: ff_wdat = {OP_PRECT, hold.x1, hold.y1, hold.color, 1'b1};
          REQ_CHAR:  ff_wdat = {OP_CHAR, hold.color, hold.bg, hold.size,
                                7'b0, 1'b1};
          default:   ff_wdat = '0;
        endcase
      end
      default: ff_wdat = '0;
    endcase
  end

endmodule
